scratchpad_mem_server: RTL and testbench

- Memory-side responder that sits directly downstream of the kernel wrapper's host-memory request port.
- Services single-word read and write requests from a local 32-bit scratchpad RAM with a configurable response latency.
- Returns one-cycle ready pulses that the wrapper's WAIT states consume.
- Provides a preload port so the testbench or host can fill the scratchpad before the kernel starts, and again between runs.

---
 rtl/scratchpad_mem_server.sv | 179 +++++++++++++++++
 tb/tb_scratchpad_mem_server.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_mem_server.sv
// scratchpad_mem_server: single-word read/write responder backed by a local
// scratchpad RAM. It answers host-memory requests after LATENCY cycles with a
// one-cycle ready pulse, and has a preload port for filling the RAM between runs.
//
// Optional feature macro: SCRATCHPAD_STATS_EN. When defined, it builds the
// rd_count/wr_count completion counters. When not defined, both outputs are tied to 0.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   base_addr                         byte address of scratchpad word 0
//   read_enable/read_addr/read_size   read request
//   write_enable/write_addr/
//     write_size/write_data           write request
//   read_ready, write_ready           bit0 = one-cycle completion pulse
//   read_data                         last read result (held)
//   preload_valid/addr/data, ready    preload write handshake (no pulse)
//   busy                              request in flight
//   err                               sticky protocol/range error
//   rd_count, wr_count                completed reads/writes
module scratchpad_mem_server #(
  parameter int unsigned ADDR_WID = 13,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [63:0]         base_addr,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic [63:0]         read_size,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [63:0]         write_size,
  input  logic [DATA_WID-1:0] write_data,
  output logic [63:0]         read_ready,
  output logic [63:0]         write_ready,
  output logic [DATA_WID-1:0] read_data,
  input  logic                preload_valid,
  input  logic [ADDR_WID-1:0] preload_addr,
  input  logic [DATA_WID-1:0] preload_data,
  output logic                preload_ready,
  output logic                busy,
  output logic                err,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_WID;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  take, rd_done, wr_done;
  logic                  rd_pulse_q, wr_pulse_q, busy_q;
  logic [DATA_WID-1:0]   read_data_q;
  logic [ADDR_WID-1:0]   req_idx;
  logic                  req_oob;
  logic [DATA_WID-1:0]   req_data;
  logic [DATA_WID-1:0]   mem [DEPTH];

  // Decode the request being sampled. A write takes priority over a read.
  logic [63:0] sel_addr, sel_size, offset, word;
  logic        oob, misaligned, preload_fire;

  always_comb begin
    sel_addr   = write_enable ? write_addr : read_addr;
    sel_size   = write_enable ? write_size : read_size;
    offset     = sel_addr - base_addr;
    word       = offset >> 2;
    oob        = (sel_addr < base_addr) || (word[63:ADDR_WID] != '0);
    misaligned = (sel_addr[1:0] != 2'b00) || (sel_size != 64'd4);
  end

  // Preload is accepted only when no kernel request competes in this cycle.
  assign preload_ready = reset_n && (state_q == IDLE) && !read_enable && !write_enable;
  assign preload_fire  = preload_ready && preload_valid;

  // Next-state, error and completion logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    take    = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (write_enable) begin
          state_d = WR_WAIT;
          take    = 1'b1;
        end else if (read_enable) begin
          state_d = RD_WAIT;
          take    = 1'b1;
        end
        if (write_enable && read_enable) err_d = 1'b1;
        if (take && (oob || misaligned)) err_d = 1'b1;
        if (take) cnt_d = CNT_W'(LATENCY - 1);
      end
      RD_WAIT, WR_WAIT: begin
        if (read_enable || write_enable) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_done = (state_q == RD_WAIT);
          wr_done = (state_q == WR_WAIT);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rd_pulse_q  <= 1'b0;
      wr_pulse_q  <= 1'b0;
      busy_q      <= 1'b0;
      read_data_q <= '0;
      req_idx     <= '0;
      req_oob     <= 1'b0;
      req_data    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_pulse_q <= rd_done;
      wr_pulse_q <= wr_done;
      busy_q     <= (state_d != IDLE);
      if (take) begin
        req_idx  <= word[ADDR_WID-1:0];
        req_oob  <= oob;
        req_data <= write_data;
      end
      if (rd_done) read_data_q <= req_oob ? '0 : mem[req_idx];
    end
  end

  // RAM contents survive reset. Kernel writes and preloads never coincide.
  always_ff @(posedge clk) begin
    if (wr_done && !req_oob) mem[req_idx] <= req_data;
    else if (preload_fire)   mem[preload_addr] <= preload_data;
  end

  assign read_ready  = {63'd0, rd_pulse_q};
  assign write_ready = {63'd0, wr_pulse_q};
  assign read_data   = read_data_q;
  assign busy        = busy_q;
  assign err         = err_q;

`ifdef SCRATCHPAD_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Counters step on the same edge that raises the matching pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_done) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_done) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_scratchpad_mem_server.sv
module tb_scratchpad_mem_server;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] base_addr;
  logic        read_enable;
  logic [63:0] read_addr;
  logic [63:0] read_size;
  logic        write_enable;
  logic [63:0] write_addr;
  logic [63:0] write_size;
  logic [31:0] write_data;
  logic [63:0] read_ready;
  logic [63:0] write_ready;
  logic [31:0] read_data;
  logic        preload_valid;
  logic [12:0] preload_addr;
  logic [31:0] preload_data;
  logic        preload_ready;
  logic        busy;
  logic        err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  // Scoreboard: kind (0 = read, 1 = write) and expected read data.
  bit          sb_kind[$];
  logic [31:0] sb_data[$];
  bit          mon_kind;
  logic [31:0] mon_data;

  scratchpad_mem_server #(.ADDR_WID(13), .DATA_WID(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
    .write_enable(write_enable), .write_addr(write_addr), .write_size(write_size),
    .write_data(write_data), .read_ready(read_ready), .write_ready(write_ready),
    .read_data(read_data), .preload_valid(preload_valid), .preload_addr(preload_addr),
    .preload_data(preload_data), .preload_ready(preload_ready), .busy(busy),
    .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] stat(input int v);
`ifdef SCRATCHPAD_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (read_ready[0] === 1'b1 || write_ready[0] === 1'b1) begin
        checks++;
        if (read_ready[63:1] !== 63'd0 || write_ready[63:1] !== 63'd0) begin
          errors++;
          $display("FAIL ready_upper_bits: read_ready=%h write_ready=%h, upper bits must be 0",
                   read_ready, write_ready);
        end
      end
      if (read_ready[0] === 1'b1) begin
        checks++;
        if (sb_kind.size() == 0 || sb_kind[0] != 1'b0) begin
          errors++;
          $display("FAIL sb_read_pulse: unexpected read pulse (queue size %0d)", sb_kind.size());
        end else begin
          mon_kind = sb_kind.pop_front();
          mon_data = sb_data.pop_front();
          if (read_data !== mon_data) begin
            errors++;
            $display("FAIL sb_read_data: got %h expected %h", read_data, mon_data);
          end
        end
      end
      if (write_ready[0] === 1'b1) begin
        checks++;
        if (sb_kind.size() == 0 || sb_kind[0] != 1'b1) begin
          errors++;
          $display("FAIL sb_write_pulse: unexpected write pulse (queue size %0d)", sb_kind.size());
        end else begin
          mon_kind = sb_kind.pop_front();
          mon_data = sb_data.pop_front();
        end
      end
    end
  end

  task automatic push_exp(input bit kind, input logic [31:0] d);
    sb_kind.push_back(kind);
    sb_data.push_back(d);
    if (kind) exp_wr++;
    else exp_rd++;
  endtask

  // Drive one request for exactly one sampling edge.
  task automatic issue(input bit wr, input bit rd, input logic [63:0] waddr,
                       input logic [63:0] raddr, input logic [31:0] wdata);
    @(posedge clk); #1;
    write_enable = wr;  write_addr = waddr; write_data = wdata;
    read_enable  = rd;  read_addr  = raddr;
    @(posedge clk); #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  // Returns the negedge index (counted after the sampling edge) of the pulse, or -1.
  task automatic wait_pulse(input bit wr, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((wr ? write_ready[0] : read_ready[0]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    preload_valid = 1'b1; preload_addr = a; preload_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (preload_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL preload_accept: word %0d not accepted within 20 cycles", a);
    end
    @(posedge clk); #1;
    preload_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    base_addr = 64'h1000;
    read_enable = 1'b0; read_addr = '0; read_size = 64'd4;
    write_enable = 1'b0; write_addr = '0; write_size = 64'd4; write_data = '0;
    preload_valid = 1'b0; preload_addr = '0; preload_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (read_ready !== 64'd0 || write_ready !== 64'd0 || read_data !== 32'd0 ||
        busy !== 1'b0 || err !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rr=%h wr=%h rd=%h busy=%b err=%b rc=%h wc=%h, all must be 0",
               read_ready, write_ready, read_data, busy, err, rd_count, wr_count);
    end
    checks++;
    if (preload_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload_ready: got %b expected 1", preload_ready);
    end
  endtask

  task automatic test_read_latency();
    int n;
    preload(13'd5, 32'hDEADBEEF);
    preload(13'd0, 32'h0BAD0000);
    preload(13'd1, 32'h11111111);
    preload(13'd6, 32'h66660000);
    preload(13'd8191, 32'h00000055);
    push_exp(1'b0, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 64'h0, 64'h1014, 32'h0);
    wait_pulse(1'b0, n);
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL read_latency: pulse at negedge %0d expected %0d", n, LAT + 1);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_resp: got %b expected 1", busy);
    end
    checks++;
    if (rd_count !== stat(exp_rd)) begin
      errors++;
      $display("FAIL rd_count_first: got %0d expected %0d", rd_count, stat(exp_rd));
    end
    @(negedge clk);
    checks++;
    if (read_ready[0] !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: read_ready0=%b busy=%b expected 0 0", read_ready[0], busy);
    end
  endtask

  task automatic test_write_read_back();
    int n;
    push_exp(1'b1, 32'h0);
    issue(1'b1, 1'b0, 64'h1008, 64'h0, 32'h12345678);
    wait_pulse(1'b1, n);
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL write_latency: pulse at negedge %0d expected %0d", n, LAT + 1);
    end
    // Issue the read back while the write pulse is visible (RESP cycle).
    push_exp(1'b0, 32'h12345678);
    read_enable = 1'b1; read_addr = 64'h1008;
    @(posedge clk); #1;
    read_enable = 1'b0;
    wait_pulse(1'b0, n);
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL resp_back_to_back: read pulse at negedge %0d expected %0d", n, LAT + 1);
    end
    checks++;
    if (wr_count !== stat(exp_wr) || rd_count !== stat(exp_rd) || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_counts: wc=%0d rc=%0d err=%b expected %0d %0d 0",
               wr_count, rd_count, err, stat(exp_wr), stat(exp_rd));
    end
  endtask

  task automatic test_out_of_range();
    int n;
    push_exp(1'b0, 32'h0);
    issue(1'b0, 1'b1, 64'h0, 64'h1000 + 64'd4 * 64'd8192, 32'h0);
    wait_pulse(1'b0, n);
    checks++;
    if (n != LAT + 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL oob_read: pulse=%0d err=%b expected %0d 1", n, err, LAT + 1);
    end
    push_exp(1'b1, 32'h0);
    issue(1'b1, 1'b0, 64'h0FFC, 64'h0, 32'hAAAAAAAA);
    wait_pulse(1'b1, n);
    checks++;
    if (n != LAT + 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL oob_write: pulse=%0d err=%b expected %0d 1", n, err, LAT + 1);
    end
    // RAM must be untouched, including the word the truncated index would hit.
    push_exp(1'b0, 32'h00000055);
    issue(1'b0, 1'b1, 64'h0, 64'h8FFC, 32'h0);
    wait_pulse(1'b0, n);
    push_exp(1'b0, 32'h0BAD0000);
    issue(1'b0, 1'b1, 64'h0, 64'h1000, 32'h0);
    wait_pulse(1'b0, n);
    checks++;
    if (rd_count !== stat(exp_rd) || wr_count !== stat(exp_wr)) begin
      errors++;
      $display("FAIL oob_counts: rc=%0d wc=%0d expected %0d %0d",
               rd_count, wr_count, stat(exp_rd), stat(exp_wr));
    end
  endtask

  task automatic test_simultaneous();
    int n;
    int rd_pulses = 0;
    apply_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_reset: got %b expected 0", err);
    end
    push_exp(1'b1, 32'h0);
    issue(1'b1, 1'b1, 64'h1004, 64'h1000, 32'h7);
    wait_pulse(1'b1, n);
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL simul_write_pulse: pulse at negedge %0d expected %0d", n, LAT + 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (read_ready[0] === 1'b1) rd_pulses++;
    end
    checks++;
    if (rd_pulses != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL simul_read_dropped: read pulses=%0d err=%b expected 0 1", rd_pulses, err);
    end
    push_exp(1'b0, 32'h7);
    issue(1'b0, 1'b1, 64'h0, 64'h1004, 32'h0);
    wait_pulse(1'b0, n);
  endtask

  task automatic test_reset_mid();
    int n;
    int rd_pulses = 0;
    issue(1'b0, 1'b1, 64'h0, 64'h1014, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || read_ready !== 64'd0 || rd_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b err=%b rr=%h rc=%0d expected all 0",
               busy, err, read_ready, rd_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (read_ready[0] === 1'b1) rd_pulses++;
    end
    checks++;
    if (rd_pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_abort: read pulses=%0d expected 0", rd_pulses);
    end
    push_exp(1'b0, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 64'h0, 64'h1014, 32'h0);
    wait_pulse(1'b0, n);
    checks++;
    if (rd_count !== stat(exp_rd) || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: rc=%0d err=%b expected %0d 0", rd_count, err, stat(exp_rd));
    end
  endtask

  task automatic test_preload_contention();
    int n;
    int acc = -1;
    @(posedge clk); #1;
    preload_valid = 1'b1; preload_addr = 13'd6; preload_data = 32'h00000066;
    read_enable = 1'b1; read_addr = 64'h1018;
    #1;
    checks++;
    if (preload_ready !== 1'b0) begin
      errors++;
      $display("FAIL preload_contention: preload_ready=%b expected 0", preload_ready);
    end
    push_exp(1'b0, 32'h66660000);
    @(posedge clk); #1;
    read_enable = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (preload_ready === 1'b1) begin
        acc = i;
        break;
      end
    end
    checks++;
    if (acc != LAT + 2) begin
      errors++;
      $display("FAIL preload_first_idle: accepted at negedge %0d expected %0d", acc, LAT + 2);
    end
    @(posedge clk); #1;
    preload_valid = 1'b0;
    push_exp(1'b0, 32'h00000066);
    issue(1'b0, 1'b1, 64'h0, 64'h1018, 32'h0);
    wait_pulse(1'b0, n);
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL preload_readback_pulse: pulse at negedge %0d expected %0d", n, LAT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read_back();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    test_preload_contention();
    repeat (4) @(negedge clk);
    checks++;
    if (sb_kind.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected completions missing, expected 0", sb_kind.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
